// File: rtl/dbg_uart_pkg.sv
// Shared definitions for the UART debug bridge: command bytes, response byte,
// FSM state encoding and the byte-write lane helper.
package dbg_uart_pkg;

   localparam logic [7:0] CMD_SETADDR = 8'h01;
   localparam logic [7:0] CMD_RDW     = 8'h02;
   localparam logic [7:0] CMD_WRW     = 8'h03;
   localparam logic [7:0] CMD_WRB     = 8'h04;
   localparam logic [7:0] CMD_PING    = 8'h05;
   localparam logic [7:0] PING_RESP   = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OPERAND = 2'd1,
      ST_BUS     = 2'd2,
      ST_TX      = 2'd3
   } state_e;

   // Big-endian bus: even byte address lives in D[15:8].
   function automatic logic [1:0] byte_lanes(input logic addr_lsb);
      return addr_lsb ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/dbg_uart_txpace.sv
// Transmit pacer: emits one-cycle dox strobes no closer than TX_GAP clocks
// apart and holds od stable between strobes.
module dbg_uart_txpace #(
   parameter int TX_GAP = 4400
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       send,
   input  logic [7:0] tx_byte,
   output logic       ready,
   output logic       dox,
   output logic [7:0] od
);

   localparam int GW = $clog2(TX_GAP + 1);

   logic [GW-1:0] gap_r;

   assign ready = (gap_r == {GW{1'b0}});

   // Strobe generation, byte hold and inter-pulse gap countdown.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         dox   <= 1'b0;
         od    <= 8'h00;
         gap_r <= {GW{1'b0}};
      end else if (send && ready) begin
         dox   <= 1'b1;
         od    <= tx_byte;
         gap_r <= GW'(TX_GAP - 1);
      end else begin
         dox <= 1'b0;
         if (gap_r != {GW{1'b0}}) begin
            gap_r <= gap_r - {{(GW-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/dbg_uart_bridge.sv
// UART-to-memory debug bridge: decodes the received command byte stream and
// runs word/byte accesses on the system bus, returning read data over UART.
module dbg_uart_bridge
   import dbg_uart_pkg::*;
#(
   parameter int BUS_CYCLES = 4,
   parameter int TX_GAP     = 4400,
   parameter int TIMEOUT    = 1048576
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        dix,
   output logic        dox,
   input  logic [7:0]  id,
   output logic [7:0]  od,
   output logic        csu,
   output logic [15:0] addru,
   output logic        ru,
   output logic [1:0]  wru,
   input  logic [15:0] data,
   output logic [15:0] datau
);

   localparam int BCW = (BUS_CYCLES > 1) ? $clog2(BUS_CYCLES) : 1;
   localparam int TW  = $clog2(TIMEOUT + 1);

   state_e         state_r, state_s;
   logic [7:0]     cmd_r;
   logic [15:0]    opb_r;
   logic [1:0]     op_left_r;
   logic [15:0]    addr_r;
   logic [BCW-1:0] bus_cnt_r;
   logic [15:0]    rdata_r;
   logic [1:0]     tx_left_r;
   logic [TW-1:0]  tmo_cnt_r;

   logic           start_bus_s;
   logic           end_bus_s;
   logic           op_done_s;
   logic           bus_last_s;
   logic           tx_send_s;
   logic [7:0]     tx_byte_s;
   logic           tx_ready_s;

   assign addru      = addr_r;
   assign bus_last_s = (bus_cnt_r == BCW'(BUS_CYCLES - 1));

   // FSM state register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_s     = state_r;
      start_bus_s = 1'b0;
      end_bus_s   = 1'b0;
      op_done_s   = 1'b0;
      tx_send_s   = 1'b0;
      tx_byte_s   = 8'h00;
      case (state_r)
         ST_IDLE: begin
            if (dix) begin
               case (id)
                  CMD_SETADDR, CMD_WRW, CMD_WRB: state_s = ST_OPERAND;
                  CMD_RDW: begin
                     state_s     = ST_BUS;
                     start_bus_s = 1'b1;
                  end
                  CMD_PING: state_s = ST_TX;
                  default:  state_s = ST_IDLE;
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_OPERAND: begin
            if (dix) begin
               if (op_left_r == 2'd1) begin
                  op_done_s = 1'b1;
                  if (cmd_r == CMD_SETADDR) begin
                     state_s = ST_IDLE;
                  end else begin
                     state_s     = ST_BUS;
                     start_bus_s = 1'b1;
                  end
               end else begin
                  state_s = ST_OPERAND;
               end
            end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_OPERAND;
            end
         end
         ST_BUS: begin
            if (bus_last_s) begin
               end_bus_s = 1'b1;
               state_s   = (cmd_r == CMD_RDW) ? ST_TX : ST_IDLE;
            end else begin
               state_s = ST_BUS;
            end
         end
         ST_TX: begin
            if (tx_ready_s) begin
               tx_send_s = 1'b1;
               if (cmd_r == CMD_PING) begin
                  tx_byte_s = PING_RESP;
               end else if (tx_left_r == 2'd2) begin
                  tx_byte_s = rdata_r[15:8];
               end else begin
                  tx_byte_s = rdata_r[7:0];
               end
               state_s = (tx_left_r == 2'd1) ? ST_IDLE : ST_TX;
            end else begin
               state_s = ST_TX;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Command capture, operand shift, address register and response byte count.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cmd_r     <= 8'h00;
         opb_r     <= 16'h0000;
         op_left_r <= 2'd0;
         addr_r    <= 16'h0000;
         tx_left_r <= 2'd0;
      end else begin
         if (state_r == ST_IDLE && dix) begin
            cmd_r     <= id;
            op_left_r <= (id == CMD_WRB) ? 2'd1 : 2'd2;
            tx_left_r <= 2'd1;
         end else if (state_r == ST_OPERAND && dix) begin
            opb_r     <= {opb_r[7:0], id};
            op_left_r <= op_left_r - 2'd1;
         end else if (end_bus_s) begin
            tx_left_r <= 2'd2;
         end else if (tx_send_s) begin
            tx_left_r <= tx_left_r - 2'd1;
         end

         if (op_done_s && cmd_r == CMD_SETADDR) begin
            addr_r <= {opb_r[7:0], id};
         end else if (end_bus_s) begin
            addr_r <= addr_r + ((cmd_r == CMD_WRB) ? 16'd1 : 16'd2);
         end
      end
   end

   // Operand inactivity counter; restarts on every received byte.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (state_r != ST_OPERAND || dix) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end
   end

   // Bus ownership window, strobes, write data and read data capture.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         csu       <= 1'b0;
         ru        <= 1'b0;
         wru       <= 2'b00;
         datau     <= 16'h0000;
         bus_cnt_r <= {BCW{1'b0}};
         rdata_r   <= 16'h0000;
      end else if (start_bus_s) begin
         csu       <= 1'b1;
         bus_cnt_r <= {BCW{1'b0}};
         if (state_r == ST_IDLE) begin
            ru  <= 1'b1;
            wru <= 2'b00;
         end else begin
            ru  <= 1'b0;
            wru <= (cmd_r == CMD_WRW) ? 2'b11 : byte_lanes(addr_r[0]);
            datau <= (cmd_r == CMD_WRW) ? {opb_r[7:0], id} : {id, id};
         end
      end else if (end_bus_s) begin
         csu     <= 1'b0;
         ru      <= 1'b0;
         wru     <= 2'b00;
         rdata_r <= data;
      end else if (state_r == ST_BUS) begin
         bus_cnt_r <= bus_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
      end
   end

   dbg_uart_txpace #(
      .TX_GAP (TX_GAP)
   ) u_txpace (
      .clk     (clk),
      .nreset  (nreset),
      .send    (tx_send_s),
      .tx_byte (tx_byte_s),
      .ready   (tx_ready_s),
      .dox     (dox),
      .od      (od)
   );

endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Directed bench for dbg_uart_bridge: command sequences with hand-computed
// bus transactions and UART responses, observed by a negedge monitor.
module tb_dbg_uart_bridge;

   localparam int BUS_CYCLES = 4;
   localparam int TX_GAP     = 40;
   localparam int TIMEOUT    = 100;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        dix = 1'b0;
   logic [7:0]  id = 8'h00;
   logic [15:0] data = 16'hBEEF;
   logic        dox;
   logic [7:0]  od;
   logic        csu;
   logic [15:0] addru;
   logic        ru;
   logic [1:0]  wru;
   logic [15:0] datau;

   int n_tests = 0;
   int n_fail  = 0;

   int          cyc = 0;
   logic        csu_q = 1'b0;
   int          csu_len = 0;
   int          last_len = 0;
   int          n_access = 0;
   int          unstable = 0;
   logic [15:0] bus_addr = 16'h0000;
   logic [15:0] bus_datau = 16'h0000;
   logic        bus_ru = 1'b0;
   logic [1:0]  bus_wru = 2'b00;
   logic [7:0]  tx_log[$];
   int          last_dox = 0;
   logic        have_dox = 1'b0;
   int          min_gap = 1000000;

   dbg_uart_bridge #(
      .BUS_CYCLES (BUS_CYCLES),
      .TX_GAP     (TX_GAP),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk    (clk),
      .nreset (nreset),
      .dix    (dix),
      .dox    (dox),
      .id     (id),
      .od     (od),
      .csu    (csu),
      .addru  (addru),
      .ru     (ru),
      .wru    (wru),
      .data   (data),
      .datau  (datau)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus window and UART transmit observer.
   always @(negedge clk) begin
      csu_q <= csu;
      if (csu) begin
         if (csu_len != 0 && (addru != bus_addr || datau != bus_datau ||
                              ru != bus_ru || wru != bus_wru))
            unstable <= unstable + 1;
         csu_len   <= csu_len + 1;
         bus_addr  <= addru;
         bus_datau <= datau;
         bus_ru    <= ru;
         bus_wru   <= wru;
      end else if (csu_q) begin
         n_access <= n_access + 1;
         last_len <= csu_len;
         csu_len  <= 0;
      end
      if (dox) begin
         tx_log.push_back(od);
         if (have_dox && (cyc - last_dox) < min_gap) min_gap <= cyc - last_dox;
         last_dox <= cyc;
         have_dox <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      id  = b;
      dix = 1'b1;
      @(negedge clk);
      dix = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_acc(input int target);
      int n = 0;
      while (n_access < target && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n_access < target) check("acc_wait", n_access, target);
   endtask

   task automatic wait_tx(input int target);
      int n = 0;
      while (tx_log.size() < target && n < 4 * TX_GAP + 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (tx_log.size() < target) check("tx_wait", tx_log.size(), target);
   endtask

   initial begin
      int base;
      int n;

      repeat (3) @(negedge clk);
      nreset = 1'b1;
      idle(2);
      check("rst_csu", csu, 1'b0);
      check("rst_dox", dox, 1'b0);
      check("rst_ru_wru", {ru, wru}, 3'b000);
      check("rst_addr", addru, 16'h0000);
      check("rst_datau", datau, 16'h0000);

      // Ping
      send(8'h05);
      wait_tx(1);
      idle(10);
      check("ping_cnt", tx_log.size(), 1);
      check("ping_byte", tx_log[0], 8'hA5);
      check("ping_nobus", n_access, 0);

      // Set address then word read
      send(8'h01); send(8'h12); send(8'h34);
      idle(3);
      check("setaddr", addru, 16'h1234);
      check("setaddr_nobus", n_access, 0);
      send(8'h02);
      wait_acc(1);
      check("rdw_len", last_len, BUS_CYCLES);
      check("rdw_addr", bus_addr, 16'h1234);
      check("rdw_strb", {bus_ru, bus_wru}, 3'b100);
      wait_tx(3);
      check("rdw_hi", tx_log[1], 8'hBE);
      check("rdw_lo", tx_log[2], 8'hEF);
      check("rdw_inc", addru, 16'h1236);

      // Word write with wrap, then read at 0x0000
      send(8'h01); send(8'hFF); send(8'hFE);
      send(8'h03); send(8'hCA); send(8'hFE);
      wait_acc(2);
      check("wrw_len", last_len, BUS_CYCLES);
      check("wrw_addr", bus_addr, 16'hFFFE);
      check("wrw_strb", {bus_ru, bus_wru}, 3'b011);
      check("wrw_data", bus_datau, 16'hCAFE);
      check("wrw_wrap", addru, 16'h0000);
      data = 16'h1357;
      send(8'h02);
      wait_acc(3);
      check("rd0_addr", bus_addr, 16'h0000);
      wait_tx(5);
      check("rd0_hi", tx_log[3], 8'h13);
      check("rd0_lo", tx_log[4], 8'h57);
      check("rd0_inc", addru, 16'h0002);

      // Byte writes at odd then even address
      send(8'h01); send(8'h20); send(8'h01);
      send(8'h04); send(8'h55);
      wait_acc(4);
      check("wrb_odd_addr", bus_addr, 16'h2001);
      check("wrb_odd_strb", {bus_ru, bus_wru}, 3'b001);
      check("wrb_odd_data", bus_datau, 16'h5555);
      check("wrb_odd_inc", addru, 16'h2002);
      send(8'h04); send(8'h66);
      wait_acc(5);
      check("wrb_even_addr", bus_addr, 16'h2002);
      check("wrb_even_strb", {bus_ru, bus_wru}, 3'b010);
      check("wrb_even_data", bus_datau, 16'h6666);
      check("wrb_even_len", last_len, BUS_CYCLES);
      check("wrb_even_inc", addru, 16'h2003);

      // Partial command times out, then ping is decoded fresh
      send(8'h01); send(8'h12);
      idle(TIMEOUT + 5);
      send(8'h05);
      wait_tx(6);
      idle(10);
      check("tmo_cnt", tx_log.size(), 6);
      check("tmo_byte", tx_log[5], 8'hA5);
      check("tmo_addr", addru, 16'h2003);
      check("tmo_nobus", n_access, 5);

      // Unknown command
      send(8'h7F);
      idle(20);
      check("unk_tx", tx_log.size(), 6);
      check("unk_bus", n_access, 5);
      check("unk_addr", addru, 16'h2003);

      // Back-to-back pings must respect the pacing gap
      send(8'h05);
      wait_tx(7);
      send(8'h05);
      wait_tx(8);
      check("gap_min", (min_gap >= TX_GAP), 1'b1);
      check("bus_stable", unstable, 0);

      // Reset during a write window
      send(8'h01); send(8'h30); send(8'h00);
      send(8'h03); send(8'h11); send(8'h22);
      n = 0;
      while (!csu && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("mid_csu_seen", csu, 1'b1);
      @(negedge clk);
      #1;
      nreset = 1'b0;
      #1;
      check("mid_csu", csu, 1'b0);
      check("mid_wru", wru, 2'b00);
      check("mid_dox", dox, 1'b0);
      check("mid_addr", addru, 16'h0000);
      idle(3);
      @(negedge clk);
      nreset = 1'b1;
      idle(3);
      base = n_access;
      data = 16'hA1B2;
      send(8'h02);
      wait_acc(base + 1);
      check("post_addr", bus_addr, 16'h0000);
      check("post_strb", {bus_ru, bus_wru}, 3'b100);
      wait_tx(10);
      check("post_hi", tx_log[8], 8'hA1);
      check("post_lo", tx_log[9], 8'hB2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dbg_uart_bridge.md
Name: dbg_uart_bridge

Overview:
- UART-to-memory debug bridge. It decodes a byte-level command stream from the UART receiver and runs 16-bit word or byte reads and writes on the system memory bus.
- Read data goes back as bytes to the UART transmitter.
- It sits beside the CPU. While csu is high, the top-level muxes the bridge's address and write data onto the bus in place of the CPU's.

Parameters:
- BUS_CYCLES, 4, clocks csu is held high per bus access (min 1).
- TX_GAP, 4400, minimum clocks between successive dox pulses (covers one 10-bit frame at 115200 baud / 50 MHz).
- TIMEOUT, 1048576, idle clocks after which a partially received command is discarded.

Ports:
- clk  in  1  system clock, all state on rising edge.
- nreset  in  1  asynchronous active-low reset.
- dix  in  1  one-cycle strobe: received byte valid on id.
- dox  out  1  one-cycle strobe: transmit byte on od.
- id  in  8  received UART byte.
- od  out  8  byte to transmit, stable from the dox pulse until the next dox.
- csu  out  1  bridge owns the memory bus.
- addru  out  16  bus byte address.
- ru  out  1  read request (valid while csu).
- wru  out  2  write lane enables, [1]=high byte D[15:8], [0]=low byte D[7:0].
- data  in  16  bus read data.
- datau  out  16  bus write data.

Behaviour:
- Reset (async, nreset low): all outputs 0, address register 0, FSM to IDLE, TX gap counter 0 (ready), timeout counter 0.
- Address register (16 bit): auto-increments after every completed access.
  - +2 for word commands, +1 for byte commands.
  - Wraps from 0xFFFF/0xFFFE modulo 2^16.
  - addru always drives the address register.
- Commands (first byte after IDLE); multi-byte operands are big-endian:
  - 0x01 AH AL: set address = {AH,AL}; no bus access.
  - 0x02: word read at addr. addr[0] is ignored for the bus, but the increment is +2. Response: data[15:8], then data[7:0].
  - 0x03 DH DL: word write {DH,DL}, wru=2'b11.
  - 0x04 D: byte write. datau={D,D}; wru=2'b10 if addr[0]=0 (big-endian), else 2'b01.
  - 0x05: ping; response one byte 0xA5; no bus access.
  - Any other first byte: ignored, stay IDLE.
- FSM states:
  - IDLE → OPERAND (collect 0..2 bytes) → BUS (BUS_CYCLES clocks) → TX (queued response bytes) → IDLE.
  - Commands without a bus access skip BUS.
  - Commands without a response skip TX.
- Bus access:
  - csu=1 for exactly BUS_CYCLES consecutive clocks.
  - During those clocks: ru=1 (read) or wru=lanes (write); addru and datau are stable.
  - Read data is sampled on the last csu clock.
  - After the access, csu, ru and wru all return to 0 in the same cycle. Address increments in that cycle.
- TX:
  - dox pulses for exactly one clock per byte, with od already valid in that clock.
  - Successive pulses are at least TX_GAP clocks apart, counted from the previous pulse.
  - The first response byte waits if the gap from the previous command's last byte has not expired.
- Bytes received (dix) while in BUS or TX are dropped.
- Timeout: in OPERAND, if no dix for TIMEOUT clocks → IDLE, command discarded, no bus access.
- Reset mid-access: csu, ru and wru deassert immediately (asynchronously); no further bus activity.

Decomposition:
- Package dbg_uart_pkg holds:
  - command byte constants: CMD_SETADDR=8'h01, CMD_RDW=8'h02, CMD_WRW=8'h03, CMD_WRB=8'h04, CMD_PING=8'h05;
  - PING_RESP=8'hA5;
  - the FSM state enum.
- One natural sub-module: dbg_uart_txpace (TX_GAP counter plus one-cycle dox generator, holds od). The rest stays flat.

Test Plan:
- Reset then ping: dix 0x05 → one dox with od=0xA5; csu never asserted.
- Set-address then word read: bytes 01 12 34 02, bus returns 0xBEEF → csu high 4 clocks with addru=0x1234, ru=1; dox od=0xBE then 0xEF, pulses ≥4400 clocks apart; addr becomes 0x1236.
- Word write with wrap: bytes 01 FF FE 03 CA FE → csu 4 clocks, addru=0xFFFE, wru=11, datau=0xCAFE; next read (02) uses addru=0x0000.
- Byte writes: bytes 01 20 01 04 55 → addru=0x2001, wru=01, datau=0x5555. Then 04 66 → addru=0x2002, wru=10, datau=0x6666.
- Timeout and unknown command: bytes 01 12, then TIMEOUT idle clocks, then 05 → only one 0xA5 response, address unchanged. Byte 0x7F → no action.
- Reset mid-access: nreset low during the csu window of a write → csu, wru and dox go 0 at once; after release an 02 reads from addru=0x0000.
